mem_stage: RTL and testbench

Memory stage of the five-stage pipeline. Consumes the 106-bit EX_MEM bundle, drives a variable-latency data-memory request/acknowledge port, stalls the front of the pipeline while an access is outstanding, and loads the resolved write-back triple into MEM_WB. Also drives the MEM-side forwarding signals used by the EX-stage forwarding unit.

---
 rtl/mem_stage.sv | 137 +++++++++++++
 tb/tb_mem_stage.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// mem_stage: memory stage of the five-stage pipeline.
// Issues a request/acknowledge data-memory access for loads and stores,
// stalls the front of the pipeline while the access is outstanding, aborts
// an access that stays unacknowledged for TIMEOUT cycles, and registers the
// resolved write-back triple into MEM_WB.
// Optional feature: define MEM_ALIGN_CHECK_EN to reject accesses whose
// address is not word aligned (no request, misalign_exc pulse, bubble).
module mem_stage #(
    parameter int TIMEOUT = 16   // legal range 2..255
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [105:0] EX_MEM,
    output logic         dmem_req,
    output logic         dmem_we,
    output logic [31:0]  dmem_addr,
    output logic [31:0]  dmem_wdata,
    input  logic         dmem_ack,
    input  logic [31:0]  dmem_rdata,
    output logic         mem_stall,
    output logic         dmem_timeout,
    output logic         misalign_exc,
    output logic         MEM_RegWrite,
    output logic [4:0]   MEM_WriteRegister,
    output logic [31:0]  MEM_RegWriteData,
    output logic [37:0]  MEM_WB
);

    typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, ABORT = 2'd2} state_t;

    localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

    state_t      state, stateNext;
    logic [7:0]  waitCnt, waitCntNext;

    logic        memRead, memWrite, access, misalign, accessOk;
    logic [1:0]  memToReg;
    logic [31:0] aluResult, pcPlus4, wbData;

    // EX_MEM bundle fields
    assign dmem_wdata        = EX_MEM[31:0];
    assign aluResult         = EX_MEM[63:32];
    assign MEM_WriteRegister = EX_MEM[68:64];
    assign memRead           = EX_MEM[69];
    assign memWrite          = EX_MEM[70];
    assign MEM_RegWrite      = EX_MEM[71];
    assign memToReg          = EX_MEM[73:72];
    assign pcPlus4           = EX_MEM[105:74];

    assign access    = memRead | memWrite;
    assign dmem_we   = memWrite;          // store wins when both are set
    assign dmem_addr = aluResult;

`ifdef MEM_ALIGN_CHECK_EN
    assign misalign = access & (aluResult[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif

    assign accessOk = access & ~misalign;

    // Reset gates req combinationally so it drops the instant rst rises.
    assign dmem_req     = accessOk & ~rst & (state != ABORT);
    assign mem_stall    = dmem_req & ~dmem_ack;
    assign dmem_timeout = (state == ABORT);
    assign misalign_exc = misalign & ~rst;

    // Forwarding value never includes load data (load-use is handled in ID).
    assign MEM_RegWriteData = memToReg[1] ? pcPlus4 : aluResult;

    // Write-back data selection
    always_comb begin
        wbData = aluResult;
        case (memToReg)
            2'b00:   wbData = aluResult;
            2'b01:   wbData = dmem_rdata;
            default: wbData = pcPlus4;
        endcase
    end

    // State and wait counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            waitCnt <= 8'd0;
        end else begin
            state   <= stateNext;
            waitCnt <= waitCntNext;
        end
    end

    // Next-state logic: track how long the current request has been pending
    always_comb begin
        stateNext   = state;
        waitCntNext = waitCnt;
        case (state)
            IDLE: begin
                if (dmem_req && !dmem_ack) begin
                    stateNext   = WAIT;
                    waitCntNext = 8'd1;
                end
            end
            WAIT: begin
                // Losing the access while waiting can only come from upstream
                // misbehaviour; fall back to IDLE rather than hang.
                if (!accessOk || dmem_ack) begin
                    stateNext   = IDLE;
                    waitCntNext = 8'd0;
                end else if (waitCnt == LAST_WAIT) begin
                    stateNext = ABORT;
                end else begin
                    waitCntNext = waitCnt + 8'd1;
                end
            end
            ABORT: begin
                stateNext   = IDLE;
                waitCntNext = 8'd0;
            end
            default: begin
                stateNext   = IDLE;
                waitCntNext = 8'd0;
            end
        endcase
    end

    // MEM_WB register: hold while stalled, bubble on abort or misalign
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            MEM_WB <= '0;
        end else if (state == ABORT || misalign) begin
            MEM_WB <= '0;
        end else if (!mem_stall) begin
            MEM_WB <= {MEM_RegWrite, MEM_WriteRegister, wbData};
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: randomized bench for mem_stage with an instruction-level
// reference model. Each instruction is described by its fields and by the
// memory latency the bench's memory will present; the expected per-cycle
// outputs and the resulting MEM_WB are derived from those directly.
module tb_mem_stage;

    localparam int TO = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [105:0] EX_MEM;
    logic         dmem_req, dmem_we, dmem_ack, mem_stall, dmem_timeout, misalign_exc;
    logic [31:0]  dmem_addr, dmem_wdata, dmem_rdata, MEM_RegWriteData;
    logic         MEM_RegWrite;
    logic [4:0]   MEM_WriteRegister;
    logic [37:0]  MEM_WB;

    mem_stage #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .EX_MEM(EX_MEM),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .mem_stall(mem_stall), .dmem_timeout(dmem_timeout), .misalign_exc(misalign_exc),
        .MEM_RegWrite(MEM_RegWrite), .MEM_WriteRegister(MEM_WriteRegister),
        .MEM_RegWriteData(MEM_RegWriteData), .MEM_WB(MEM_WB)
    );

    always #5 clk = ~clk;

    int nCmp = 0;
    int nBad = 0;
    int reqCnt = 0, stallCnt = 0, toCnt = 0, misCnt = 0, weCnt = 0;

    // Model-side expected MEM_WB; bubbles only pin RegWrite = 0
    logic [37:0] eWb = '0;
    logic        wbBubble = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nCmp++;
        if (act !== exp) begin
            nBad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Runs one instruction through MEM; called at posedge+1, returns at posedge+1
    task automatic runInstr(input logic [31:0] sd, input logic [31:0] addr, input logic [4:0] rd,
                            input logic mr, input logic mw, input logic rw, input logic [1:0] m2r,
                            input logic [31:0] pc4, input int lat, input logic [31:0] rdv);
        logic access, mis, abrt, eReq, eStall;
        logic [31:0] wsel, eRwd;
        int nCyc;
        access = mr | mw;
`ifdef MEM_ALIGN_CHECK_EN
        mis = access && (addr[1:0] != 2'b00);
`else
        mis = 1'b0;
`endif
        if (!access || mis) nCyc = 1;
        else if (lat < TO)  nCyc = lat + 1;
        else                nCyc = TO + 1;
        EX_MEM = {pc4, m2r, rw, mw, mr, rd, addr, sd};
        eRwd = m2r[1] ? pc4 : addr;
        for (int k = 0; k < nCyc; k++) begin
            abrt = access && !mis && lat >= TO && k == TO;
            eReq = access && !mis && !abrt;
            if (eReq) dmem_ack = (k == lat);
            else      dmem_ack = 1'($urandom % 2);   // must be ignored
            dmem_rdata = (k == nCyc - 1) ? rdv : $urandom;
            eStall = eReq && !dmem_ack;
            @(negedge clk);
            chk("req", dmem_req, eReq);
            chk("stall", mem_stall, eStall);
            chk("timeout", dmem_timeout, abrt);
            chk("misalign", misalign_exc, mis);
            chk("we", dmem_we, mw);
            chk("addr", dmem_addr, addr);
            chk("wdata", dmem_wdata, sd);
            chk("fwd_rw", MEM_RegWrite, rw);
            chk("fwd_rd", MEM_WriteRegister, rd);
            chk("fwd_data", MEM_RegWriteData, eRwd);
            if (wbBubble) chk("wb_bubble", MEM_WB[37], 1'b0);
            else          chk("wb", MEM_WB, eWb);
            reqCnt   += int'(dmem_req);
            stallCnt += int'(mem_stall);
            toCnt    += int'(dmem_timeout);
            misCnt   += int'(misalign_exc);
            weCnt    += int'(dmem_req && dmem_we);
            @(posedge clk);
            if (k == nCyc - 1) begin
                if (abrt || mis) begin
                    wbBubble = 1'b1;
                end else begin
                    case (m2r)
                        2'b00:   wsel = addr;
                        2'b01:   wsel = rdv;
                        default: wsel = pc4;
                    endcase
                    eWb = {rw, rd, wsel};
                    wbBubble = 1'b0;
                end
            end
            #1;
        end
    endtask

    initial begin
        int r0, s0, t0, m0, w0, op, lat;
        logic [31:0] a;
        rst = 1'b1;
        EX_MEM = '0;
        dmem_ack = 1'b0;
        dmem_rdata = '0;
        #1;
        chk("reset_wb", MEM_WB, 38'd0);
        chk("reset_req", dmem_req, 1'b0);
        chk("reset_stall", mem_stall, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;

        // ALU op, rd 8, result 0x1234
        runInstr(32'h0, 32'h1234, 5'd8, 1'b0, 1'b0, 1'b1, 2'b00, 32'h4, 0, 32'h0);
        chk("alu_wb_lit", MEM_WB, {1'b1, 5'd8, 32'h00001234});

        // Load at 0x100, ack on the 4th request cycle
        r0 = reqCnt; s0 = stallCnt;
        runInstr(32'h0, 32'h100, 5'd9, 1'b1, 1'b0, 1'b1, 2'b01, 32'h8, 3, 32'hDEADBEEF);
        chk("load_stall_cycles", stallCnt - s0, 3);
        chk("load_req_cycles", reqCnt - r0, 4);
        chk("load_wb_lit", MEM_WB, {1'b1, 5'd9, 32'hDEADBEEF});

        // Zero-wait store
        r0 = reqCnt; s0 = stallCnt; w0 = weCnt;
        runInstr(32'hA5A5A5A5, 32'h200, 5'd3, 1'b0, 1'b1, 1'b0, 2'b00, 32'hC, 0, 32'h0);
        chk("store_we_cycles", weCnt - w0, 1);
        chk("store_stall_cycles", stallCnt - s0, 0);
        chk("store_wb_rw", MEM_WB[37], 1'b0);

        // Jal
        runInstr(32'h0, 32'h7777, 5'd31, 1'b0, 1'b0, 1'b1, 2'b10, 32'h00400008, 0, 32'h0);
        chk("jal_wb_lit", MEM_WB, {1'b1, 5'd31, 32'h00400008});

        // Load never acknowledged
        r0 = reqCnt; t0 = toCnt;
        runInstr(32'h0, 32'h300, 5'd10, 1'b1, 1'b0, 1'b1, 2'b01, 32'h10, 99, 32'h0);
        chk("to_req_cycles", reqCnt - r0, TO);
        chk("to_pulses", toCnt - t0, 1);
        chk("to_wb_rw", MEM_WB[37], 1'b0);

        // Reset mid-WAIT: make MEM_WB nonzero first
        runInstr(32'h0, 32'h55, 5'd4, 1'b0, 1'b0, 1'b1, 2'b00, 32'h14, 0, 32'h0);
        EX_MEM = {32'h18, 2'b01, 1'b1, 1'b0, 1'b1, 5'd6, 32'h400, 32'h0};
        dmem_ack = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk("pre_rst_req", dmem_req, 1'b1);
        rst = 1'b1;
        #1;
        chk("rst_req_drop", dmem_req, 1'b0);
        chk("rst_wb_clear", MEM_WB, 38'd0);
        EX_MEM = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        eWb = '0;
        wbBubble = 1'b0;

`ifdef MEM_ALIGN_CHECK_EN
        r0 = reqCnt; m0 = misCnt;
        runInstr(32'h0, 32'h102, 5'd7, 1'b1, 1'b0, 1'b1, 2'b01, 32'h1C, 0, 32'h0);
        chk("mis_req_cycles", reqCnt - r0, 0);
        chk("mis_pulses", misCnt - m0, 1);
        chk("mis_wb_rw", MEM_WB[37], 1'b0);
`endif
        m0 = misCnt;

        // Randomized instruction stream
        for (int n = 0; n < 300; n++) begin
            op  = $urandom_range(0, 3);
            lat = $urandom_range(0, TO + 1);
            a   = $urandom;
            if ($urandom_range(0, 7) != 0) a[1:0] = 2'b00;
            runInstr($urandom, a, 5'($urandom), op == 1 || op == 3, op == 2 || op == 3,
                     1'($urandom), 2'($urandom), $urandom, lat, $urandom);
        end
`ifndef MEM_ALIGN_CHECK_EN
        chk("no_misalign", misCnt - m0, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

endmodule
